fir_coeff_bank: RTL and testbench

Coefficient register bank directly downstream of the FIR AXI4-Lite interface block: it consumes the interface's address/coefficient/strobe outputs, returns the write/read acknowledges, and drives the FIR datapath with a double-buffered coefficient set. Writes land in a shadow bank. A software-armed swap copies shadow to active on the next frame start, so taps never change mid-frame. An optional readback path returns shadow values to the bus side.

---
 rtl/fir_coeff_bank_if.sv | 34 +++
 rtl/fir_coeff_bank.sv | 176 +++++++++++++++++
 tb/tb_fir_coeff_bank.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coeff_bank_if.sv
// fir_coeff_bank_if: four-phase strobe/acknowledge bus between the FIR
// AXI4-Lite front end (master) and the coefficient bank (slave).
interface fir_coeff_bank_if;
    logic [7:0]  fir_addr_i;
    logic [31:0] fir_coeff_i;
    logic        wr_strobe_i;
    logic        wr_ack_o;
    logic [7:0]  rd_addr_i;
    logic        rd_strobe_i;
    logic        rd_ack_o;
    logic [31:0] rd_data_o;

    modport master (
        output fir_addr_i,
        output fir_coeff_i,
        output wr_strobe_i,
        output rd_addr_i,
        output rd_strobe_i,
        input  wr_ack_o,
        input  rd_ack_o,
        input  rd_data_o
    );

    modport slave (
        input  fir_addr_i,
        input  fir_coeff_i,
        input  wr_strobe_i,
        input  rd_addr_i,
        input  rd_strobe_i,
        output wr_ack_o,
        output rd_ack_o,
        output rd_data_o
    );
endinterface

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: double-buffered FIR coefficient register bank.
// Bus writes land in a shadow bank; a software-armed swap copies the shadow
// bank to the active bank on the next frame start so taps never change
// mid-frame. Strobes arrive asynchronously and are handled by a four-phase
// handshake FSM behind 2-flop synchronisers.
// Optional feature macro: FIR_COEFF_READBACK_EN enables shadow/control readback;
// without it the read handshake still completes but returns 0.
module fir_coeff_bank #(
    parameter int NTAPS = 16,
    parameter int CW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    fir_coeff_bank_if.slave     bus,
    input  logic                frame_start_i,
    output logic [NTAPS*CW-1:0] coeff_o,
    output logic                coeff_update_o
);

    localparam logic [7:0]           CTRL_ADDR = 8'hFC;
    // 1.0 in Q1.(CW-2): the reset bank is a pass-through filter
    localparam logic signed [CW-1:0] COEF_ONE  = {2'b01, {(CW-2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_HOLD = 2'd1,
        RD_HOLD = 2'd2
    } state_t;

    state_t               state;
    logic                 ws1, ws2, rs1, rs2;
    logic signed [CW-1:0] shadow [NTAPS];
    logic signed [CW-1:0] active [NTAPS];
    logic                 swap_pending;
    logic                 wr_fire;
    logic                 swap;
    logic                 arm;
    logic                 unused_bits;

    // Write is performed on the IDLE->WR_HOLD edge; write beats read
    assign wr_fire = (state == IDLE) && ws2;
    assign swap    = frame_start_i && swap_pending;
    assign arm     = wr_fire && (bus.fir_addr_i == CTRL_ADDR) && bus.fir_coeff_i[0];

    // Upper data bits and (without readback) the read address carry no meaning here
    assign unused_bits = ^{bus.fir_coeff_i, bus.rd_addr_i};

    // Two-flop synchronisers for the asynchronous request strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            ws1 <= 1'b0;
            ws2 <= 1'b0;
            rs1 <= 1'b0;
            rs2 <= 1'b0;
        end else begin
            ws1 <= bus.wr_strobe_i;
            ws2 <= ws1;
            rs1 <= bus.rd_strobe_i;
            rs2 <= rs1;
        end
    end

    // Four-phase handshake FSM with registered acknowledges
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.wr_ack_o <= 1'b0;
            bus.rd_ack_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ws2) begin
                        state        <= WR_HOLD;
                        bus.wr_ack_o <= 1'b1;
                    end else if (rs2) begin
                        state        <= RD_HOLD;
                        bus.rd_ack_o <= 1'b1;
                    end
                end
                WR_HOLD: begin
                    if (!ws2) begin
                        state        <= IDLE;
                        bus.wr_ack_o <= 1'b0;
                    end
                end
                RD_HOLD: begin
                    if (!rs2) begin
                        state        <= IDLE;
                        bus.rd_ack_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.wr_ack_o <= 1'b0;
                    bus.rd_ack_o <= 1'b0;
                end
            endcase
        end
    end

    // Shadow writes, swap arming and shadow->active copy at frame start.
    // The copy samples shadow before any same-edge write lands; an arm on
    // the same edge as a swap re-arms for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k] <= (k == 0) ? COEF_ONE : '0;
                active[k] <= (k == 0) ? COEF_ONE : '0;
            end
            swap_pending   <= 1'b0;
            coeff_update_o <= 1'b0;
        end else begin
            coeff_update_o <= swap;
            for (int k = 0; k < NTAPS; k++) begin
                if (swap) begin
                    active[k] <= shadow[k];
                end
                if (wr_fire && (bus.fir_addr_i[7:2] == 6'(k))) begin
                    shadow[k] <= bus.fir_coeff_i[CW-1:0];
                end
            end
            if (arm) begin
                swap_pending <= 1'b1;
            end else if (swap) begin
                swap_pending <= 1'b0;
            end
        end
    end

    // Flatten the active bank onto the datapath bus, tap k at [k*CW +: CW]
    always_comb begin
        coeff_o = '0;
        for (int k = 0; k < NTAPS; k++) begin
            coeff_o[k*CW +: CW] = active[k];
        end
    end

`ifdef FIR_COEFF_READBACK_EN
    logic        rd_fire;
    logic [31:0] rd_mux;

    function automatic logic [31:0] sext32(input logic signed [CW-1:0] v);
        return 32'(v);
    endfunction

    assign rd_fire = (state == IDLE) && !ws2 && rs2;

    // Readback mux: shadow tap (sign-extended), control register, else 0
    always_comb begin
        rd_mux = '0;
        if (bus.rd_addr_i == CTRL_ADDR) begin
            rd_mux = {31'b0, swap_pending};
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                if (bus.rd_addr_i[7:2] == 6'(k)) begin
                    rd_mux = sext32(shadow[k]);
                end
            end
        end
    end

    // Read data is captured when the read is accepted and cleared on release
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data_o <= '0;
        end else if (rd_fire) begin
            bus.rd_data_o <= rd_mux;
        end else if ((state == RD_HOLD) && !rs2) begin
            bus.rd_data_o <= '0;
        end
    end
`else
    assign bus.rd_data_o = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_bank.sv
// tb_fir_coeff_bank: directed and randomized checks of fir_coeff_bank
// against a transaction-level model of the shadow/active banks.
module tb_fir_coeff_bank;

    localparam int NTAPS = 16;
    localparam int CW    = 16;
`ifdef FIR_COEFF_READBACK_EN
    localparam logic [31:0] RB_TAP1 = 32'hFFFF_C000;
`else
    localparam logic [31:0] RB_TAP1 = 32'h0;
`endif

    logic                clk;
    logic                rst;
    logic                frame_start_i;
    logic [NTAPS*CW-1:0] coeff_o;
    logic                coeff_update_o;

    fir_coeff_bank_if bus();

    fir_coeff_bank #(.NTAPS(NTAPS), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .frame_start_i  (frame_start_i),
        .coeff_o        (coeff_o),
        .coeff_update_o (coeff_update_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int fs_rate  = 0;
    bit started  = 0;

    // Model: banks indexed directly by the 6-bit tap field of the address
    logic [CW-1:0] m_shadow [64];
    logic [CW-1:0] m_active [64];
    logic          m_pending;
    logic          m_upd;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NTAPS*CW-1:0] m_flat();
        logic [NTAPS*CW-1:0] r;
        r = '0;
        for (int k = 0; k < NTAPS; k++) r[k*CW +: CW] = m_active[k];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
`ifdef FIR_COEFF_READBACK_EN
        logic [5:0] idx;
        idx = a[7:2];
        if (a == 8'hFC) return {31'b0, m_pending};
        if (idx < NTAPS) return {{(32-CW){m_shadow[idx][CW-1]}}, m_shadow[idx]};
        return 32'h0;
`else
        return 32'h0 | {24'b0, a & 8'h00};
`endif
    endfunction

    function automatic bit rfs();
        return (fs_rate != 0) && ($urandom_range(0, fs_rate - 1) == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 64; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_shadow[0] = 16'h4000;
        m_active[0] = 16'h4000;
        m_pending   = 1'b0;
        m_upd       = 1'b0;
    endtask

    // One clock edge; wr_edge marks the edge on which the bench expects the write
    task automatic step(input bit wr_edge, input bit fs);
        logic [5:0] idx;
        bit         sw;
        frame_start_i = fs;
        @(posedge clk);
        if (rst) begin
            model_reset();
            started = 1;
        end else begin
            sw    = fs && m_pending;
            m_upd = sw;
            if (sw) m_active = m_shadow;
            idx = bus.fir_addr_i[7:2];
            if (wr_edge && idx < NTAPS) m_shadow[idx] = bus.fir_coeff_i[CW-1:0];
            if (wr_edge && bus.fir_addr_i == 8'hFC && bus.fir_coeff_i[0]) m_pending = 1'b1;
            else if (sw) m_pending = 1'b0;
        end
        #1;
        frame_start_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input bit fs_w, input int hold);
        bus.fir_addr_i  = a;
        bus.fir_coeff_i = d;
        bus.wr_strobe_i = 1'b1;
        step(0, rfs());
        step(0, rfs());
        check("wr_ack_early", bus.wr_ack_o, 1'b0);
        step(1, fs_w ? 1'b1 : rfs());
        check("wr_ack_rise", bus.wr_ack_o, 1'b1);
        repeat (hold) step(0, rfs());
        bus.wr_strobe_i = 1'b0;
        step(0, rfs());
        step(0, rfs());
        check("wr_ack_hold", bus.wr_ack_o, 1'b1);
        step(0, rfs());
        check("wr_ack_fall", bus.wr_ack_o, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a, input int hold, output logic [31:0] got);
        logic [31:0] exp;
        bus.rd_addr_i   = a;
        bus.rd_strobe_i = 1'b1;
        step(0, rfs());
        step(0, rfs());
        check("rd_ack_early", bus.rd_ack_o, 1'b0);
        exp = m_read(a);
        step(0, rfs());
        check("rd_ack_rise", bus.rd_ack_o, 1'b1);
        check("rd_data", bus.rd_data_o, exp);
        got = bus.rd_data_o;
        repeat (hold) step(0, rfs());
        bus.rd_strobe_i = 1'b0;
        step(0, rfs());
        step(0, rfs());
        check("rd_ack_hold", bus.rd_ack_o, 1'b1);
        check("rd_data_hold", bus.rd_data_o, exp);
        step(0, rfs());
        check("rd_ack_fall", bus.rd_ack_o, 1'b0);
        check("rd_data_fall", bus.rd_data_o, 32'h0);
    endtask

    // Every-cycle comparison of the datapath outputs against the model
    always @(negedge clk) begin
        if (started) begin
            check("coeff_o", coeff_o, m_flat());
            check("coeff_update_o", coeff_update_o, m_upd);
        end
    end

    initial begin
        logic [31:0] got;
        logic [31:0] d;
        logic [7:0]  a;
        int          op;

        rst             = 1'b1;
        frame_start_i   = 1'b0;
        bus.fir_addr_i  = '0;
        bus.fir_coeff_i = '0;
        bus.wr_strobe_i = 1'b0;
        bus.rd_addr_i   = '0;
        bus.rd_strobe_i = 1'b0;
        #2;
        step(0, 0);
        step(0, 0);
        rst = 1'b0;
        step(0, 0);

        // Reset state, literal
        check("rst_tap0", coeff_o[15:0], 16'h4000);
        check("rst_taps", coeff_o[NTAPS*CW-1:16], '0);
        check("rst_wr_ack", bus.wr_ack_o, 1'b0);
        check("rst_rd_ack", bus.rd_ack_o, 1'b0);
        check("rst_upd", coeff_update_o, 1'b0);

        // Shadow isolation
        wr(8'h08, 32'hFFFF_C000, 0, 1);
        check("iso_tap2", coeff_o[47:32], 16'h0000);

        // Arm then frame start
        wr(8'hFC, 32'h1, 0, 0);
        check("armed_tap2", coeff_o[47:32], 16'h0000);
        step(0, 1);
        check("swap_tap2", coeff_o[47:32], 16'hC000);
        check("swap_upd", coeff_update_o, 1'b1);
        step(0, 0);
        check("swap_upd_once", coeff_update_o, 1'b0);
        rd(8'hFC, 0, got);
        check("ctrl_after_swap", got, 32'h0);

        // Arm coinciding with frame start: swap deferred
        wr(8'h08, 32'h0000_1234, 0, 0);
        wr(8'hFC, 32'h1, 1, 0);
        check("coinc_no_swap", coeff_o[47:32], 16'hC000);
        step(0, 1);
        check("coinc_next_swap", coeff_o[47:32], 16'h1234);

        // Shadow write on the swap edge: old shadow is copied
        wr(8'hFC, 32'h1, 0, 0);
        wr(8'h0C, 32'h0000_7777, 1, 0);
        check("wr_on_swap_tap3", coeff_o[63:48], 16'h0000);
        wr(8'hFC, 32'h1, 0, 0);
        step(0, 1);
        check("wr_on_swap_next", coeff_o[63:48], 16'h7777);

        // Simultaneous strobes: write first, then read
        bus.fir_addr_i  = 8'h04;
        bus.fir_coeff_i = 32'hFFFF_C000;
        bus.rd_addr_i   = 8'h04;
        bus.wr_strobe_i = 1'b1;
        bus.rd_strobe_i = 1'b1;
        step(0, 0);
        step(0, 0);
        step(1, 0);
        check("sim_wr_ack", bus.wr_ack_o, 1'b1);
        check("sim_rd_wait", bus.rd_ack_o, 1'b0);
        bus.wr_strobe_i = 1'b0;
        step(0, 0);
        step(0, 0);
        step(0, 0);
        check("sim_wr_done", bus.wr_ack_o, 1'b0);
        check("sim_rd_still", bus.rd_ack_o, 1'b0);
        step(0, 0);
        check("sim_rd_ack", bus.rd_ack_o, 1'b1);
        check("sim_rd_data", bus.rd_data_o, RB_TAP1);
        bus.rd_strobe_i = 1'b0;
        repeat (3) step(0, 0);
        check("sim_rd_fall", bus.rd_ack_o, 1'b0);

        // Out of range
        wr(8'h40, 32'h0000_5555, 0, 0);
        rd(8'h40, 0, got);
        check("oor_read", got, 32'h0);
        wr(8'hFC, 32'h1, 0, 0);
        step(0, 1);

        // Reset mid-handshake: ack drops, held strobe is a new request
        bus.fir_addr_i  = 8'h10;
        bus.fir_coeff_i = 32'h0000_2222;
        bus.wr_strobe_i = 1'b1;
        step(0, 0);
        step(0, 0);
        step(1, 0);
        check("mid_ack", bus.wr_ack_o, 1'b1);
        rst = 1'b1;
        step(0, 0);
        check("mid_rst_ack", bus.wr_ack_o, 1'b0);
        rst = 1'b0;
        step(0, 0);
        step(0, 0);
        check("mid_new_early", bus.wr_ack_o, 1'b0);
        step(1, 0);
        check("mid_new_ack", bus.wr_ack_o, 1'b1);
        bus.wr_strobe_i = 1'b0;
        repeat (3) step(0, 0);
        check("mid_new_fall", bus.wr_ack_o, 1'b0);

        // Randomized traffic with random frame starts
        fs_rate = 5;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    a = {6'($urandom_range(0, 19)), 2'($urandom_range(0, 3))};
                    wr(a, $urandom, 0, $urandom_range(0, 2));
                end
                1: begin
                    d    = $urandom;
                    d[0] = ($urandom_range(0, 3) != 0);
                    wr(8'hFC, d, 0, 0);
                end
                2: begin
                    if ($urandom_range(0, 4) == 0) a = 8'hFC;
                    else a = {6'($urandom_range(0, 19)), 2'($urandom_range(0, 3))};
                    rd(a, $urandom_range(0, 2), got);
                end
                default: begin
                    repeat ($urandom_range(1, 4)) step(0, rfs());
                end
            endcase
        end
        fs_rate = 0;
        step(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
